// File: rtl/ram_arbiter.sv
// Two-master arbiter for a single-port ram (async read, sync write) with registered read return.
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed m0 priority with m1 starvation relief.
module ram_arbiter #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_wen,
  input  logic [DEPTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic [WIDTH-1:0] m0_rdata,
  output logic             m0_rvalid,
  input  logic             m1_req,
  input  logic             m1_wen,
  input  logic [DEPTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic [WIDTH-1:0] m1_rdata,
  output logic             m1_rvalid,
  output logic             ram_ena,
  output logic             ram_wena,
  output logic [DEPTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout
);

  typedef enum logic {PRI0, PRI1} state_t;

  state_t             state_q, state_d;
  logic               gnt0, gnt1;
  logic [WIDTH-1:0]   m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic               m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;

`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;
  logic          starved;

  assign starved = (starve_q == SW'(STARVE_MAX));

  always_comb begin
    gnt1    = m1_req & (~m0_req | starved);
    gnt0    = m0_req & ~gnt1;
    state_d = PRI0;
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    starve_d = starve_q;
    if (!m1_req || gnt1) starve_d = '0;
    else if (!starved)   starve_d = starve_q + SW'(1);
  end
`else
  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX != 0);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == PRI0) begin
      if (m0_req)      gnt0 = 1'b1;
      else if (m1_req) gnt1 = 1'b1;
    end else begin
      if (m1_req)      gnt1 = 1'b1;
      else if (m0_req) gnt0 = 1'b1;
    end
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    // Granting m0 hands priority to m1 and vice versa; a non-priority grant leaves it unchanged.
    state_d = gnt0 ? PRI1 : (gnt1 ? PRI0 : state_q);
  end
`endif

  always_comb begin
    ram_ena  = gnt0 | gnt1;
    ram_wena = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt0) begin
      ram_wena = m0_wen;
      ram_addr = m0_addr;
      ram_din  = m0_wdata;
    end else if (gnt1) begin
      ram_wena = m1_wen;
      ram_addr = m1_addr;
      ram_din  = m1_wdata;
    end
    m0_rvalid_d = gnt0 & ~m0_wen;
    m1_rvalid_d = gnt1 & ~m1_wen;
    m0_rdata_d  = m0_rvalid_d ? ram_dout : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? ram_dout : m1_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PRI0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
`ifdef RAM_ARB_FIXED_PRIO_EN
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
`ifdef RAM_ARB_FIXED_PRIO_EN
      starve_q    <= starve_d;
`endif
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed per-cycle vectors, read results checked by a scoreboard monitor.
module tb_ram_arbiter;
  logic        clk, rst;
  logic        m0_req, m0_wen, m1_req, m1_wen;
  logic [9:0]  m0_addr, m1_addr, ram_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ram_din, ram_dout;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_ena, ram_wena;

  logic [31:0] mem [1024];
  logic [31:0] q0[$], q1[$];
  int          n_vec = 0, n_err = 0;
  bit          no_push = 0;

  ram_arbiter #(.WIDTH(32), .DEPTH(10), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ram: async read, write on the grant edge.
  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_ena && ram_wena) mem[ram_addr] <= ram_din;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m0_rvalid === 1'b1) begin
      if (q0.size() == 0) chk("m0_rvalid_unexpected", 32'(m0_rvalid), 32'd0);
      else chk("m0_rdata", m0_rdata, q0.pop_front());
    end
    if (m1_rvalid === 1'b1) begin
      if (q1.size() == 0) chk("m1_rvalid_unexpected", 32'(m1_rvalid), 32'd0);
      else chk("m1_rdata", m1_rdata, q1.pop_front());
    end
  end

  task automatic cyc(input logic r0, input logic w0, input logic [9:0] a0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [9:0] a1, input logic [31:0] d1,
                     input logic eg0, input logic eg1, input logic [31:0] erd);
    @(posedge clk); #1;
    m0_req = r0; m0_wen = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_wen = w1; m1_addr = a1; m1_wdata = d1;
    @(negedge clk);
    chk("m0_gnt", 32'(m0_gnt), 32'(eg0));
    chk("m1_gnt", 32'(m1_gnt), 32'(eg1));
    chk("ram_ena", 32'(ram_ena), 32'(eg0 | eg1));
    if (eg0) chk("ram_addr_m0", 32'(ram_addr), 32'(a0));
    if (eg1) chk("ram_addr_m1", 32'(ram_addr), 32'(a1));
    if (eg0 && !w0 && !no_push) q0.push_back(erd);
    if (eg1 && !w1 && !no_push) q1.push_back(erd);
  endtask

  task automatic idle();
    cyc(0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0, 0, 0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    rst = 1'b1;
    m0_req = 1; m0_wen = 0; m0_addr = 10'd0; m0_wdata = 32'd0;
    m1_req = 1; m1_wen = 0; m1_addr = 10'd0; m1_wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_ram_ena", 32'(ram_ena), 32'd0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    m0_req = 0; m1_req = 0;
    rst = 1'b0;

    // First contention after reset goes to m0
    cyc(1, 1, 10'd7, 32'h11, 1, 1, 10'd8, 32'h22, 1, 0, 32'd0);
    cyc(0, 0, 10'd0, 32'd0, 1, 1, 10'd8, 32'h22, 0, 1, 32'd0);

    // m0 write then read-back, m1 idle
    cyc(1, 1, 10'd5, 32'hDEADBEEF, 0, 0, 10'd0, 32'd0, 1, 0, 32'd0);
    cyc(1, 0, 10'd5, 32'd0, 0, 0, 10'd0, 32'd0, 1, 0, 32'hDEADBEEF);
    idle();
    cyc(0, 0, 10'd0, 32'd0, 1, 1, 10'd9, 32'h33, 0, 1, 32'd0);

    // Same-address write by m0 and read by m1 in the same cycle
    cyc(1, 1, 10'd3, 32'h12, 1, 0, 10'd3, 32'd0, 1, 0, 32'd0);
    cyc(0, 0, 10'd0, 32'd0, 1, 0, 10'd3, 32'd0, 0, 1, 32'h12);
    idle();

`ifdef RAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) cyc(1, 0, 10'd7, 32'd0, 1, 0, 10'd8, 32'd0, 0, 1, 32'h22);
      else                  cyc(1, 0, 10'd7, 32'd0, 1, 0, 10'd8, 32'd0, 1, 0, 32'h11);
    end
`else
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) cyc(1, 0, 10'd7, 32'd0, 1, 0, 10'd8, 32'd0, 1, 0, 32'h11);
      else            cyc(1, 0, 10'd7, 32'd0, 1, 0, 10'd8, 32'd0, 0, 1, 32'h22);
    end
`endif
    idle();

    // m1 read, then reset lands on the cycle its rvalid would show
    no_push = 1;
    cyc(0, 0, 10'd0, 32'd0, 1, 0, 10'd9, 32'd0, 0, 1, 32'd0);
    no_push = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    m0_req = 1; m0_wen = 0; m1_req = 1; m1_wen = 0;
    @(negedge clk);
    chk("rst2_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("rst2_m1_rdata", m1_rdata, 32'd0);
    chk("rst2_ram_ena", 32'(ram_ena), 32'd0);
    chk("rst2_m0_gnt", 32'(m0_gnt), 32'd0);
    m0_req = 0; m1_req = 0;
    rst = 1'b0;

    cyc(1, 1, 10'd10, 32'h44, 1, 1, 10'd11, 32'h55, 1, 0, 32'd0);
`ifdef RAM_ARB_FIXED_PRIO_EN
    cyc(1, 1, 10'd10, 32'h44, 1, 1, 10'd11, 32'h55, 1, 0, 32'd0);
    cyc(0, 0, 10'd0, 32'd0, 1, 1, 10'd11, 32'h55, 0, 1, 32'd0);
`else
    cyc(0, 0, 10'd0, 32'd0, 1, 1, 10'd11, 32'h55, 0, 1, 32'd0);
`endif
    cyc(1, 0, 10'd10, 32'd0, 0, 0, 10'd0, 32'd0, 1, 0, 32'h44);
    cyc(0, 0, 10'd0, 32'd0, 1, 0, 10'd11, 32'd0, 0, 1, 32'h55);
    idle();
    idle();

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
